// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder and the core's LSU path.
// Holds the RV load/store funct3 encoding, the responder FSM states and
// a small helper that turns an access size into a byte-lane mask.
package ControlSignals;

    // Width of the wait-state counter (WAIT_STATES is at most 15).
    localparam int DMEM_WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    // Lane mask for an access of 1/2/4/8 bytes starting at lane 0.
    function automatic logic [7:0] size_lanes(input logic [1:0] size_code);
        logic [7:0] lanes;
        case (size_code)
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/data_mem_responder_load_extender.sv
// load_extender: picks the addressed lanes out of a raw doubleword and
// sign- or zero-extends them according to the load funct3.
// Purely combinational so the core's LSU can reuse it directly.
module load_extender
    import ControlSignals::*;
(
    input  logic [63:0]  raw_i,
    input  logic [2:0]   lane_i,
    input  mem_funct3_t  funct3_i,
    output logic [63:0]  ext_o
);

    logic [31:0] lane_data;

    // Shift the addressed byte down to bit 0, then extend by access type.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        ext_o     = '0;
        lane_data = 32'(raw_i >> {lane_i, 3'b000});
        case (funct3_i)
            MEM_B:   ext_o = {{56{lane_data[7]}},  lane_data[7:0]};
            MEM_H:   ext_o = {{48{lane_data[15]}}, lane_data[15:0]};
            MEM_W:   ext_o = {{32{lane_data[31]}}, lane_data[31:0]};
            MEM_D:   ext_o = raw_i;
            MEM_BU:  ext_o = {56'd0, lane_data[7:0]};
            MEM_HU:  ext_o = {48'd0, lane_data[15:0]};
            MEM_WU:  ext_o = {32'd0, lane_data[31:0]};
            default: ext_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder in front of
// an on-chip doubleword array. Request is latched in IDLE, optionally
// stalled in WAIT, performed in a single ACCESS cycle and presented in
// RESP until the requester takes it.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault every access that is
// not naturally aligned; otherwise only doubleword-crossing accesses fault.
module data_mem_responder
    import ControlSignals::*;
#(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int MEM_DEPTH_POW      = 10,
    parameter int WAIT_STATES        = 1
)
(
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_write_in,
    input  logic [2:0]  req_funct3_in,
    input  logic [63:0] req_addr_in,
    input  logic [63:0] req_wdata_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic [63:0] rsp_rdata_out,
    output logic        rsp_err_out
);

    localparam int XLEN  = 1 << REG_DATA_WIDTH_POW;
    localparam int DEPTH = 1 << MEM_DEPTH_POW;
    localparam int LANES = XLEN / 8;

    dmem_state_t                  state_q,    state_d;
    logic [DMEM_WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                         write_q,    write_d;
    logic [2:0]                   funct3_q,   funct3_d;
    logic [63:0]                  addr_q,     addr_d;
    logic [XLEN-1:0]              wdata_q,    wdata_d;
    logic [XLEN-1:0]              rdata_q,    rdata_d;
    logic                         err_q,      err_d;

    logic [XLEN-1:0]              mem_array [DEPTH];

    logic [2:0]                   lane;
    logic [MEM_DEPTH_POW-1:0]     mem_idx;
    logic [15:0]                  lane_mask_wide;
    logic [LANES-1:0]             byte_en;
    logic                         cross_err;
    logic                         range_err;
    logic                         funct3_err;
    logic                         store_err;
    logic                         misalign_err;
    logic                         access_err;
    logic [XLEN-1:0]              store_data;
    logic [XLEN-1:0]              mem_rdata;
    logic [63:0]                  load_ext;
    logic                         mem_we;

    // Address decode, byte enables and fault detection on the latched request.
    assign lane           = addr_q[2:0];
    assign mem_idx        = addr_q[MEM_DEPTH_POW+2:3];
    assign lane_mask_wide = {8'h00, size_lanes(funct3_q[1:0])} << lane;
    assign byte_en        = lane_mask_wide[7:0];
    assign cross_err      = |lane_mask_wide[15:8];
    assign range_err      = |addr_q[63:MEM_DEPTH_POW+3];
    assign funct3_err     = (funct3_q == 3'b111);
    assign store_err      = write_q & funct3_q[2];

`ifdef DMEM_MISALIGN_TRAP_EN
    // Alignment mask per size: B 000, H 001, W 011, D 111.
    assign misalign_err = |(addr_q[2:0] &
                            {funct3_q[1] & funct3_q[0], funct3_q[1], |funct3_q[1:0]});
`else
    assign misalign_err = 1'b0;
`endif

    assign access_err = range_err | funct3_err | store_err | cross_err | misalign_err;
    assign store_data = wdata_q << {lane, 3'b000};
    assign mem_rdata  = mem_array[mem_idx];
    assign mem_we     = (state_q == ACCESS) & write_q & ~access_err;

    load_extender u_load_extender (
        .raw_i    (mem_rdata),
        .lane_i   (lane),
        .funct3_i (mem_funct3_t'(funct3_q)),
        .ext_o    (load_ext)
    );

    // Handshake outputs come straight from the state register.
    assign req_ready_out = (state_q == IDLE) & ~reset;
    assign rsp_valid_out = (state_q == RESP);
    assign rsp_rdata_out = rdata_q;
    assign rsp_err_out   = err_q;

    // Next-state logic: accept, stall, perform the access, hold the response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_in && req_ready_out) begin
                    write_d    = req_write_in;
                    funct3_d   = req_funct3_in;
                    addr_d     = req_addr_in;
                    wdata_d    = req_wdata_in;
                    wait_cnt_d = '0;
                    state_d    = (WAIT_STATES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == DMEM_WAIT_CNT_W'(WAIT_STATES - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ACCESS: begin
                err_d   = access_err;
                rdata_d = (access_err || write_q) ? '0 : load_ext;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            write_q    <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            write_q    <= write_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Byte-lane writes into the data array during ACCESS.
    always_ff @(posedge clk_in) begin
        // NOTE: the array has no reset so it maps onto plain RAM; its
        // contents survive a reset of the control logic.
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (byte_en[i]) begin
                    mem_array[mem_idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed vectors plus randomized
// traffic checked against a byte-array reference model through a scoreboard.
module tb_data_mem_responder;

    localparam int WAIT_STATES = 1;
    localparam int MEM_BYTES   = 8192;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic        req_write_in = 1'b0;
    logic [2:0]  req_funct3_in = 3'd0;
    logic [63:0] req_addr_in = '0;
    logic [63:0] req_wdata_in = '0;
    logic        rsp_valid_out;
    logic        rsp_ready_in = 1'b1;
    logic [63:0] rsp_rdata_out;
    logic        rsp_err_out;

    data_mem_responder #(
        .REG_DATA_WIDTH_POW (6),
        .MEM_DEPTH_POW      (10),
        .WAIT_STATES        (WAIT_STATES)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .req_write_in  (req_write_in),
        .req_funct3_in (req_funct3_in),
        .req_addr_in   (req_addr_in),
        .req_wdata_in  (req_wdata_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_rdata_out (rsp_rdata_out),
        .rsp_err_out   (rsp_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  mdl [0:MEM_BYTES-1];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%016h expected=0x%016h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Reference model: memory as a flat byte array, access rules from the
    // architectural definition of each load/store size.
    task automatic model_access(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wd, output logic err, output logic [63:0] rd);
        int unsigned size;
        logic [63:0] val;
        size = 1 << f3[1:0];
        err  = 1'b0;
        rd   = '0;
        if (f3 == 3'b111)                    err = 1'b1;
        if (wr && f3[2])                     err = 1'b1;
        if (addr >= 64'(MEM_BYTES))          err = 1'b1;
        if (int'(addr[2:0]) + size > 8)      err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % 64'(size)) != 0)         err = 1'b1;
`endif
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < int'(size); i++)
                    mdl[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int i = 0; i < int'(size); i++)
                    val[8*i +: 8] = mdl[int'(addr) + i];
                if (!f3[2] && size < 8 && val[8*size-1])
                    val = val | (~64'd0 << (8*size));
                rd = val;
            end
        end
    endtask

    // Issue one request; the expected response enters the scoreboard when
    // the accept edge is known to be coming.
    task automatic send(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input bit use_exp, input logic xerr,
                        input logic [63:0] xrd, output logic [63:0] mrd);
        logic m_err;
        rsp_t e;
        int   n;
        model_access(wr, f3, addr, wd, m_err, mrd);
        req_valid_in  = 1'b1;
        req_write_in  = wr;
        req_funct3_in = f3;
        req_addr_in   = addr;
        req_wdata_in  = wd;
        n = 0;
        forever begin
            @(negedge clk_in);
            if (req_ready_out) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: req_ready_out never rose for addr 0x%016h", addr);
                req_valid_in = 1'b0;
                return;
            end
        end
        e.err   = use_exp ? xerr : m_err;
        e.rdata = use_exp ? xrd  : mrd;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        acc_cyc      = cyc;
        req_valid_in = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic xact(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd);
        logic [63:0] dummy;
        send(wr, f3, addr, wd, 1'b0, 1'b0, '0, dummy);
        wait_done();
    endtask

    task automatic xact_exp(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wd, input logic xerr, input logic [63:0] xrd);
        logic [63:0] dummy;
        send(wr, f3, addr, wd, 1'b1, xerr, xrd, dummy);
        wait_done();
    endtask

    // Monitor: latency of every response and scoreboard compare on handshake.
    always @(negedge clk_in) begin
        rsp_t e;
        if (!reset) begin
            if (rsp_valid_out && !prev_valid)
                check("latency", 64'(cyc - acc_cyc), 64'(WAIT_STATES + 1));
            if (rsp_valid_out && rsp_ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rdata=0x%016h err=%0b", rsp_rdata_out, rsp_err_out);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", 64'(rsp_err_out), 64'(e.err));
                    check("rsp_rdata", rsp_rdata_out, e.rdata);
                end
            end
        end
        prev_valid = rsp_valid_out;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mrd;
        bit          wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        int          n;

        // Reset state.
        repeat (2) @(negedge clk_in);
        check("rst_req_ready", 64'(req_ready_out), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
        check("rst_rsp_rdata", rsp_rdata_out, 64'd0);
        check("rst_rsp_err",   64'(rsp_err_out), 64'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        @(negedge clk_in);
        check("post_rst_ready", 64'(req_ready_out), 64'd1);
        @(posedge clk_in);
        #1;

        // Directed vectors.
        xact_exp(1'b1, 3'b011, 64'h40, 64'h1122334455667788, 1'b0, 64'd0);
        xact_exp(1'b0, 3'b011, 64'h40, 64'd0, 1'b0, 64'h1122334455667788);
        xact_exp(1'b1, 3'b000, 64'h43, 64'h80, 1'b0, 64'd0);
        xact_exp(1'b0, 3'b000, 64'h43, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF80);
        xact_exp(1'b0, 3'b100, 64'h43, 64'd0, 1'b0, 64'h80);
        xact_exp(1'b0, 3'b011, 64'h40, 64'd0, 1'b0, 64'h1122334480667788);
`ifdef DMEM_MISALIGN_TRAP_EN
        xact_exp(1'b0, 3'b001, 64'h41, 64'd0, 1'b1, 64'd0);
`else
        xact_exp(1'b0, 3'b001, 64'h41, 64'd0, 1'b0, 64'h6677);
`endif
        xact_exp(1'b0, 3'b010, 64'h46, 64'd0, 1'b1, 64'd0);
        xact_exp(1'b1, 3'b011, 64'h0, 64'hA5A5A5A55A5A5A5A, 1'b0, 64'd0);
        xact_exp(1'b1, 3'b011, 64'h2000, 64'hDEADBEEFDEADBEEF, 1'b1, 64'd0);
        xact_exp(1'b0, 3'b011, 64'h0, 64'd0, 1'b0, 64'hA5A5A5A55A5A5A5A);
        xact_exp(1'b0, 3'b111, 64'h40, 64'd0, 1'b1, 64'd0);
        xact_exp(1'b1, 3'b100, 64'h40, 64'hFF, 1'b1, 64'd0);
        xact(1'b0, 3'b011, 64'h40, 64'd0);

        // Back-pressure: response must stay put while rsp_ready_in is low;
        // a store presented meanwhile must be ignored.
        rsp_ready_in = 1'b0;
        send(1'b0, 3'b011, 64'h40, 64'd0, 1'b0, 1'b0, '0, mrd);
        n = 0;
        while (!rsp_valid_out && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        req_valid_in  = 1'b1;
        req_write_in  = 1'b1;
        req_funct3_in = 3'b011;
        req_addr_in   = 64'h40;
        req_wdata_in  = 64'hCAFECAFECAFECAFE;
        repeat (5) begin
            @(negedge clk_in);
            check("hold_valid", 64'(rsp_valid_out), 64'd1);
            check("hold_rdata", rsp_rdata_out, mrd);
            check("hold_err",   64'(rsp_err_out), 64'd0);
            check("hold_ready", 64'(req_ready_out), 64'd0);
        end
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
        rsp_ready_in = 1'b1;
        wait_done();
        xact(1'b0, 3'b011, 64'h40, 64'd0);

        // Reset while the request is in WAIT: dropped without a response.
        send(1'b0, 3'b011, 64'h40, 64'd0, 1'b0, 1'b0, '0, mrd);
        reset = 1'b1;
        @(negedge clk_in);
        check("wait_rst_ready", 64'(req_ready_out), 64'd0);
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk_in);
        check("after_rst_ready", 64'(req_ready_out), 64'd1);
        check("after_rst_valid", 64'(rsp_valid_out), 64'd0);
        repeat (3) begin
            @(negedge clk_in);
            check("dropped_no_rsp", 64'(rsp_valid_out), 64'd0);
        end
        @(posedge clk_in);
        #1;
        xact(1'b0, 3'b011, 64'h40, 64'd0);

        // Randomized traffic over a preloaded window plus out-of-range hits.
        for (int i = 0; i < 16; i++)
            xact(1'b1, 3'b011, 64'(i * 8), {$urandom, $urandom});
        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0)
                addr = {$urandom, $urandom} | 64'h1_0000_0000;
            else
                addr = 64'($urandom_range(0, 127));
            xact(wr, f3, addr, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
